// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: register geometry and the
// flattened per-requester bus slice convention.
`timescale 1ns/1ps
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // Requester k of a flattened bus with per-slot width w occupies [w*k +: w].
  function automatic int unsigned slice_lo(int unsigned k, int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr (wrapping),
// returning a one-hot grant and its encoded index. Reusable by any shared resource.
`timescale 1ns/1ps
module rr_arbiter_core #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  input  logic            i_hold,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx
);

  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_sel;
  logic [NREQ-1:0] w_first;

  // Requests at or above ptr take priority; if none, wrap to the lowest requester overall.
  assign w_mask  = ~((NREQ'(1) << i_ptr) - NREQ'(1));
  assign w_hi    = i_req & w_mask;
  assign w_sel   = (|w_hi) ? w_hi : i_req;
  assign w_first = w_sel & (~w_sel + NREQ'(1));
  assign o_gnt   = i_hold ? '0 : w_first;

  for (genvar b = 0; b < PW; b++) begin : g_enc
    logic [NREQ-1:0] w_bit_mask;
    for (genvar k = 0; k < NREQ; k++) begin : g_k
      assign w_bit_mask[k] = (((k >> b) & 1) == 1);
    end
    assign o_idx[b] = |(o_gnt & w_bit_mask);
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ writeback
// sources, with a registered write stage. Define WB_BYPASS_EN to add write-to-read forwarding.
`timescale 1ns/1ps
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = REG_AW,
  parameter int unsigned DW   = REG_DW,
  parameter int unsigned PW   = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             hold,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [AW*NREQ-1:0] req_addr,
  input  logic [DW*NREQ-1:0] req_data,
  output logic             WR,
  output logic [AW-1:0]    WA,
  output logic [DW-1:0]    WD,
  output logic [PW-1:0]    grant_id,
  output logic             idle
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  input  logic [DW-1:0]    RDA_in,
  input  logic [DW-1:0]    RDB_in,
  output logic [DW-1:0]    RDA_out,
  output logic [DW-1:0]    RDB_out
`endif
);

  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_idx;
  logic            w_xfer;
  logic [PW-1:0]   w_ptr_next;
  logic [AW-1:0]   w_addr_acc [NREQ+1];
  logic [DW-1:0]   w_data_acc [NREQ+1];
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;

  logic            r_wr;
  logic [AW-1:0]   r_wa;
  logic [DW-1:0]   r_wd;
  logic [PW-1:0]   r_gid;
  logic [PW-1:0]   r_ptr;

  // Reset is folded into hold so no requester sees a grant while the block is in reset.
  rr_arbiter_core #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .i_hold (hold | Reset),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );

  assign req_ready = w_gnt;
  assign w_xfer    = |w_gnt;

  // One-hot AND-OR mux of the winner's address/data.
  assign w_addr_acc[0] = '0;
  assign w_data_acc[0] = '0;
  for (genvar k = 0; k < NREQ; k++) begin : g_mux
    localparam int unsigned AddrLo = slice_lo(k, AW);
    localparam int unsigned DataLo = slice_lo(k, DW);
    assign w_addr_acc[k+1] = w_addr_acc[k] | (req_addr[AddrLo +: AW] & {AW{w_gnt[k]}});
    assign w_data_acc[k+1] = w_data_acc[k] | (req_data[DataLo +: DW] & {DW{w_gnt[k]}});
  end
  assign w_sel_addr = w_addr_acc[NREQ];
  assign w_sel_data = w_data_acc[NREQ];

  assign w_ptr_next = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr  <= 1'b0;
      r_wa  <= '0;
      r_wd  <= '0;
      r_gid <= '0;
      r_ptr <= '0;
    end else begin
      // Writes to $0 are accepted and recorded but never enabled.
      r_wr <= w_xfer && (w_sel_addr != AW'(REG_ZERO));
      if (w_xfer) begin
        r_wa  <= w_sel_addr;
        r_wd  <= w_sel_data;
        r_gid <= w_idx;
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign WR       = r_wr;
  assign WA       = r_wa;
  assign WD       = r_wd;
  assign grant_id = r_gid;
  assign idle     = ~(|req_valid) & ~r_wr;

`ifdef WB_BYPASS_EN
  assign RDA_out = (r_wr && (r_wa == RA) && (RA != AW'(REG_ZERO))) ? r_wd : RDA_in;
  assign RDB_out = (r_wr && (r_wa == RB) && (RB != AW'(REG_ZERO))) ? r_wd : RDB_in;
`endif

endmodule
